// File: rtl/sub_adder_bist.sv
`default_nettype none
// ============================================================================
// Module   : sub_adder_bist
// Purpose  : Self-test controller for the adder/subtractor: four directed
//            corner patterns, then LFSR patterns, checked against a model.
// Revision : 1.0  initial release
// ============================================================================
module sub_adder_bist #(
    parameter int          WIDTH         = 16,
    parameter int          NUM_PATTERNS  = 10000,
    parameter int          SETTLE_CYCLES = 1,
    parameter logic [31:0] LFSR_SEED     = 32'hACE1_1234
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] dut_a,
    output logic [WIDTH-1:0] dut_b,
    output logic             dut_mode,
    input  logic [WIDTH-1:0] dut_sum,
    input  logic             dut_cout,
    input  logic             dut_ovf,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [16:0]      err_count,
    output logic [13:0]      first_err_idx
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_APPLY  = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam int              c_SW           = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [c_SW-1:0] c_SETTLE_LAST  = c_SW'(SETTLE_CYCLES - 1);
    localparam logic [13:0]     c_LAST_IDX     = 14'(NUM_PATTERNS - 1);

    logic [2:0]       r_state;
    logic [13:0]      r_idx;
    logic [31:0]      r_lfsr;
    logic [c_SW-1:0]  r_settle_cnt;
    logic [WIDTH-1:0] r_exp_sum;
    logic             r_exp_cout;
    logic             r_exp_ovf;

    logic [31:0]      w_lfsr_next;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic             w_mode;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_ref;
    logic             w_ref_ovf;
    logic             w_mis_sum;
    logic             w_mis_cout;
    logic             w_mis_ovf;
    logic [17:0]      w_err_sum;
    logic [16:0]      w_err_next;

    // Taps x^32+x^22+x^2+x+1; the register advances on every APPLY,
    // directed patterns included, so random pattern 4 sees the 5th shift.
    assign w_lfsr_next = {r_lfsr[30:0], r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1] ^ r_lfsr[0]};

    always_comb begin
        w_a    = WIDTH'(w_lfsr_next[15:0]);
        w_b    = WIDTH'(w_lfsr_next[31:16]);
        w_mode = w_lfsr_next[7];
        case (r_idx)
            14'd0: begin w_a = WIDTH'(16'h7FFF); w_b = WIDTH'(16'h0001); w_mode = 1'b0; end
            14'd1: begin w_a = WIDTH'(16'h8000); w_b = WIDTH'(16'h0001); w_mode = 1'b1; end
            14'd2: begin w_a = WIDTH'(16'hFFFF); w_b = WIDTH'(16'h0001); w_mode = 1'b0; end
            14'd3: begin w_a = WIDTH'(16'h0000); w_b = WIDTH'(16'h0001); w_mode = 1'b1; end
            default: ;
        endcase
    end

    // Subtract is a + ~b + 1, so cout=1 means no borrow.
    assign w_b_eff   = w_mode ? ~w_b : w_b;
    assign w_ref     = {1'b0, w_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_mode};
    assign w_ref_ovf = (w_a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_ref[WIDTH-1] != w_a[WIDTH-1]);

    // Case inequality so X/Z on the responses counts as a mismatch.
    assign w_mis_sum  = (dut_sum  !== r_exp_sum);
    assign w_mis_cout = (dut_cout !== r_exp_cout);
    assign w_mis_ovf  = (dut_ovf  !== r_exp_ovf);
    assign w_err_sum  = {1'b0, err_count} + {17'd0, w_mis_sum} + {17'd0, w_mis_cout}
                      + {17'd0, w_mis_ovf};
    assign w_err_next = w_err_sum[17] ? 17'h1FFFF : w_err_sum[16:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_idx         <= 14'd0;
            r_lfsr        <= LFSR_SEED;
            r_settle_cnt  <= '0;
            r_exp_sum     <= '0;
            r_exp_cout    <= 1'b0;
            r_exp_ovf     <= 1'b0;
            dut_a         <= '0;
            dut_b         <= '0;
            dut_mode      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= 17'd0;
            first_err_idx <= 14'd0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state       <= S_APPLY;
                        r_idx         <= 14'd0;
                        r_lfsr        <= LFSR_SEED;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        pass          <= 1'b0;
                        err_count     <= 17'd0;
                        first_err_idx <= 14'd0;
                    end
                end
                S_APPLY: begin
                    r_lfsr       <= w_lfsr_next;
                    dut_a        <= w_a;
                    dut_b        <= w_b;
                    dut_mode     <= w_mode;
                    r_exp_sum    <= w_ref[WIDTH-1:0];
                    r_exp_cout   <= w_ref[WIDTH];
                    r_exp_ovf    <= w_ref_ovf;
                    r_settle_cnt <= '0;
                    r_state      <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (r_settle_cnt == c_SETTLE_LAST) begin
                        r_state <= S_CHECK;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + c_SW'(1);
                    end
                end
                S_CHECK: begin
                    err_count <= w_err_next;
                    if ((w_mis_sum || w_mis_cout || w_mis_ovf) && (err_count == 17'd0)) begin
                        first_err_idx <= r_idx;
                    end
                    if (r_idx == c_LAST_IDX) begin
                        r_state <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= (w_err_next == 17'd0);
                    end else begin
                        r_idx   <= r_idx + 14'd1;
                        r_state <= S_APPLY;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sub_adder_bist.sv
`default_nettype none
// ============================================================================
// Module   : tb_sub_adder_bist
// Purpose  : Scoreboard bench for sub_adder_bist with a behavioural adder
//            that can carry a stuck-carry or inverted-sum fault.
// Revision : 1.0  initial release
// ============================================================================
module tb_sub_adder_bist;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_s = 1'b0;
    logic start_f = 1'b0;
    int   fault = 0;

    logic [15:0] s_a, s_b, s_sum, f_a, f_b, f_sum;
    logic        s_mode, s_cout, s_ovf, s_busy, s_done, s_pass;
    logic        f_mode, f_cout, f_ovf, f_busy, f_done, f_pass;
    logic [16:0] s_err, f_err;
    logic [13:0] s_fidx, f_fidx;

    int n_vec  = 0;
    int n_miss = 0;

    logic [32:0] q_s[$];
    logic [32:0] q_f[$];
    logic [32:0] last_p;
    logic        s_act = 1'b0, f_act = 1'b0;
    int          s_cyc = 0, f_cyc = 0;

    always #5 clk = ~clk;

    function automatic logic [17:0] adder(input logic [15:0] a, input logic [15:0] b,
                                          input logic m, input int flt);
        logic [15:0] bx;
        logic [16:0] r;
        logic        o;
        bx = m ? ~b : b;
        r  = {1'b0, a} + {1'b0, bx} + {16'd0, m};
        o  = (a[15] == bx[15]) && (r[15] != a[15]);
        if (flt == 1) r[16] = 1'b0;
        if (flt == 2) r[15:0] = ~r[15:0];
        return {o, r};
    endfunction

    assign {s_ovf, s_cout, s_sum} = adder(s_a, s_b, s_mode, fault);
    assign {f_ovf, f_cout, f_sum} = adder(f_a, f_b, f_mode, fault);

    sub_adder_bist #(.NUM_PATTERNS(4)) u_small (
        .clk(clk), .rst(rst), .start(start_s),
        .dut_a(s_a), .dut_b(s_b), .dut_mode(s_mode),
        .dut_sum(s_sum), .dut_cout(s_cout), .dut_ovf(s_ovf),
        .busy(s_busy), .done(s_done), .pass(s_pass),
        .err_count(s_err), .first_err_idx(s_fidx)
    );

    sub_adder_bist u_full (
        .clk(clk), .rst(rst), .start(start_f),
        .dut_a(f_a), .dut_b(f_b), .dut_mode(f_mode),
        .dut_sum(f_sum), .dut_cout(f_cout), .dut_ovf(f_ovf),
        .busy(f_busy), .done(f_done), .pass(f_pass),
        .err_count(f_err), .first_err_idx(f_fidx)
    );

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return {l[30:0], ^(l & 32'h8020_0003)};
    endfunction

    // Expected {mode,b,a} stream for one run, queued as the run is launched.
    task automatic push_patterns(input int which, input int n);
        logic [31:0] l;
        logic [32:0] p;
        l = 32'hACE1_1234;
        for (int i = 0; i < n; i++) begin
            l = lfsr_step(l);
            case (i)
                0: p = {1'b0, 16'h0001, 16'h7FFF};
                1: p = {1'b1, 16'h0001, 16'h8000};
                2: p = {1'b0, 16'h0001, 16'hFFFF};
                3: p = {1'b1, 16'h0001, 16'h0000};
                default: p = {l[7], l[31:16], l[15:0]};
            endcase
            if (which == 0) q_s.push_back(p); else q_f.push_back(p);
            last_p = p;
        end
    endtask

    // Pattern k is on dut_* from the edge 3k+1 cycles after the start edge.
    always @(posedge clk) begin
        if (rst) s_act <= 1'b0;
        else if (start_s && !s_busy) begin s_act <= 1'b1; s_cyc <= 0; end
        else if (s_act) s_cyc <= s_cyc + 1;
        if (rst) f_act <= 1'b0;
        else if (start_f && !f_busy) begin f_act <= 1'b1; f_cyc <= 0; end
        else if (f_act) f_cyc <= f_cyc + 1;
    end

    always @(negedge clk) begin
        logic [32:0] p;
        if (!rst && s_act && (s_cyc % 3 == 1) && (s_cyc <= 10)) begin
            n_vec++;
            if (q_s.size() == 0) begin
                n_miss++;
                $display("FAIL small_sb_underflow: pattern %0d has no expected entry", s_cyc / 3);
            end else begin
                p = q_s.pop_front();
                if ({s_mode, s_b, s_a} !== p) begin
                    n_miss++;
                    $display("FAIL small_pattern %0d: got %h expected %h", s_cyc / 3, {s_mode, s_b, s_a}, p);
                end
            end
        end
        if (!rst && f_act && (f_cyc % 3 == 1) && (f_cyc <= 29998)) begin
            n_vec++;
            if (q_f.size() == 0) begin
                n_miss++;
                $display("FAIL full_sb_underflow: pattern %0d has no expected entry", f_cyc / 3);
            end else begin
                p = q_f.pop_front();
                if ({f_mode, f_b, f_a} !== p) begin
                    n_miss++;
                    $display("FAIL full_pattern %0d: got %h expected %h", f_cyc / 3, {f_mode, f_b, f_a}, p);
                end
            end
        end
    end

    task automatic start_run(input int which);
        @(negedge clk);
        if (which == 0) start_s = 1'b1; else start_f = 1'b1;
        @(posedge clk);
        #1;
        start_s = 1'b0;
        start_f = 1'b0;
    endtask

    // Cycles from APPLY entry until done; pulse_at>0 re-pulses start mid-run.
    task automatic wait_done(input int which, input int bound, input int pulse_at, output int cyc);
        cyc = 0;
        while (cyc < bound) begin
            @(posedge clk);
            cyc++;
            #1;
            start_s = (which == 0) && (cyc == pulse_at);
            if ((which == 0 && s_done) || (which == 1 && f_done)) break;
        end
        start_s = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({s_a, s_b, s_mode, s_busy, s_done, s_pass, s_err, s_fidx} !== '0) begin
            n_miss++;
            $display("FAIL reset_small: a=%h b=%h m=%b busy=%b done=%b pass=%b err=%0d idx=%0d expected all 0",
                     s_a, s_b, s_mode, s_busy, s_done, s_pass, s_err, s_fidx);
        end
        n_vec++;
        if ({f_a, f_b, f_mode, f_busy, f_done, f_pass, f_err, f_fidx} !== '0) begin
            n_miss++;
            $display("FAIL reset_full: a=%h b=%h m=%b busy=%b done=%b pass=%b err=%0d idx=%0d expected all 0",
                     f_a, f_b, f_mode, f_busy, f_done, f_pass, f_err, f_fidx);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed;
        int cyc;
        fault = 0;
        push_patterns(0, 4);
        start_run(0);
        n_vec++;
        if (s_busy !== 1'b1 || s_done !== 1'b0) begin
            n_miss++;
            $display("FAIL directed_busy: busy=%b done=%b expected busy=1 done=0", s_busy, s_done);
        end
        wait_done(0, 40, 0, cyc);
        n_vec++;
        if (cyc !== 12 || s_done !== 1'b1 || s_busy !== 1'b0) begin
            n_miss++;
            $display("FAIL directed_latency: cycles=%0d done=%b busy=%b expected 12/1/0", cyc, s_done, s_busy);
        end
        n_vec++;
        if (s_pass !== 1'b1 || s_err !== 17'd0 || s_fidx !== 14'd0) begin
            n_miss++;
            $display("FAIL directed_result: pass=%b err=%0d idx=%0d expected 1/0/0", s_pass, s_err, s_fidx);
        end
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({s_mode, s_b, s_a} !== last_p || s_done !== 1'b1) begin
            n_miss++;
            $display("FAIL directed_hold: got %h done=%b expected %h done=1", {s_mode, s_b, s_a}, s_done, last_p);
        end
    endtask

    task automatic test_stuck_cout;
        int cyc;
        fault = 1;
        push_patterns(0, 4);
        start_run(0);
        wait_done(0, 40, 0, cyc);
        n_vec++;
        if (s_err !== 17'd2 || s_fidx !== 14'd1 || s_pass !== 1'b0 || cyc !== 12) begin
            n_miss++;
            $display("FAIL stuck_cout: err=%0d idx=%0d pass=%b cycles=%0d expected 2/1/0/12", s_err, s_fidx, s_pass, cyc);
        end
    endtask

    task automatic test_start_busy_and_restart;
        int cyc;
        fault = 1;
        push_patterns(0, 4);
        start_run(0);
        wait_done(0, 40, 5, cyc);
        n_vec++;
        if (s_err !== 17'd2 || s_fidx !== 14'd1 || cyc !== 12) begin
            n_miss++;
            $display("FAIL start_while_busy: err=%0d idx=%0d cycles=%0d expected 2/1/12", s_err, s_fidx, cyc);
        end
        push_patterns(0, 4);
        start_run(0);
        n_vec++;
        if (s_done !== 1'b0 || s_pass !== 1'b0 || s_err !== 17'd0 || s_fidx !== 14'd0 || s_busy !== 1'b1) begin
            n_miss++;
            $display("FAIL restart_clear: done=%b pass=%b err=%0d idx=%0d busy=%b expected 0/0/0/0/1",
                     s_done, s_pass, s_err, s_fidx, s_busy);
        end
        wait_done(0, 40, 0, cyc);
        n_vec++;
        if (s_err !== 17'd2 || cyc !== 12) begin
            n_miss++;
            $display("FAIL restart_rerun: err=%0d cycles=%0d expected 2/12", s_err, cyc);
        end
    endtask

    task automatic test_reset_midrun;
        int cyc;
        fault = 0;
        push_patterns(0, 4);
        start_run(0);
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if ({s_a, s_b, s_mode, s_busy, s_done, s_pass, s_err, s_fidx} !== '0) begin
            n_miss++;
            $display("FAIL reset_midrun: a=%h b=%h m=%b busy=%b done=%b err=%0d expected all 0",
                     s_a, s_b, s_mode, s_busy, s_done, s_err);
        end
        @(negedge clk);
        rst = 1'b0;
        q_s.delete();
        repeat (2) @(posedge clk);
        push_patterns(0, 4);
        start_run(0);
        wait_done(0, 40, 0, cyc);
        n_vec++;
        if (cyc !== 12 || s_pass !== 1'b1 || s_err !== 17'd0) begin
            n_miss++;
            $display("FAIL after_reset_run: cycles=%0d pass=%b err=%0d expected 12/1/0", cyc, s_pass, s_err);
        end
    endtask

    task automatic test_random_full;
        int cyc;
        fault = 0;
        push_patterns(1, 10000);
        start_run(1);
        wait_done(1, 31000, 0, cyc);
        n_vec++;
        if (cyc !== 30000 || f_pass !== 1'b1 || f_err !== 17'd0 || f_fidx !== 14'd0) begin
            n_miss++;
            $display("FAIL full_run: cycles=%0d pass=%b err=%0d idx=%0d expected 30000/1/0/0", cyc, f_pass, f_err, f_fidx);
        end
        n_vec++;
        if ({f_mode, f_b, f_a} !== last_p) begin
            n_miss++;
            $display("FAIL full_hold: got %h expected %h", {f_mode, f_b, f_a}, last_p);
        end
    endtask

    // Second start on the same instance: the scoreboard demands the same stream.
    task automatic test_back_to_back_inverted;
        int cyc;
        fault = 2;
        push_patterns(1, 10000);
        start_run(1);
        wait_done(1, 31000, 0, cyc);
        n_vec++;
        if (cyc !== 30000 || f_err < 17'd10000 || f_fidx !== 14'd0 || f_pass !== 1'b0) begin
            n_miss++;
            $display("FAIL inverted_sum: cycles=%0d err=%0d idx=%0d pass=%b expected 30000/>=10000/0/0",
                     cyc, f_err, f_fidx, f_pass);
        end
        n_vec++;
        if (q_s.size() != 0 || q_f.size() != 0) begin
            n_miss++;
            $display("FAIL sb_leftover: small=%0d full=%0d expected 0/0", q_s.size(), q_f.size());
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stuck_cout();
        test_start_busy_and_restart();
        test_reset_midrun();
        test_random_full();
        test_back_to_back_inverted();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sub_adder_bist.md
Name: sub_adder_bist

Overview:
Built-in self-test controller for the 16-bit adder/subtractor. It is the hardware counterpart of the software pattern bench. It generates operand/mode stimulus (four directed corner patterns, then LFSR pseudo-random patterns) and drives them into the adder. It samples the adder's sum/carry/overflow responses, compares them against an internal reference model, and counts mismatches. It sits beside the adder and is started by a test-mode controller or a top-level bench.

Parameters:
WIDTH, 16, operand width (directed patterns assume 16)
NUM_PATTERNS, 10000, total patterns per run including the 4 directed ones (minimum 4)
SETTLE_CYCLES, 1, cycles between driving operands and sampling responses (minimum 1)
LFSR_SEED, 32'hACE1_1234, non-zero LFSR load value at each start

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous active-high reset
start  input  1  one-cycle pulse; starts a run when not busy
dut_a  output  WIDTH  operand A to adder (registered)
dut_b  output  WIDTH  operand B to adder (registered)
dut_mode  output  1  0 = add, 1 = subtract (registered)
dut_sum  input  WIDTH  adder sum
dut_cout  input  1  adder carry out
dut_ovf  input  1  adder signed-overflow flag
busy  output  1  high from the cycle after start until done
done  output  1  high after the run completes; held until next start or rst
pass  output  1  valid when done=1; 1 iff err_count==0
err_count  output  17  field-mismatch count, saturates at 17'h1FFFF
first_err_idx  output  14  index of the first failing pattern; 0 if none

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values: dut_a=0, dut_b=0, dut_mode=0, busy=0, done=0, pass=0, err_count=0, first_err_idx=0, FSM=IDLE, pattern index=0, LFSR=LFSR_SEED.
- rst asserted mid-run aborts the run immediately to the reset state. No partial result is retained.
- FSM states: IDLE, APPLY, SETTLE, CHECK, DONE.
  - IDLE, or DONE, with start=1 → APPLY. On that edge: clear err_count, first_err_idx, done, pass; reload LFSR with LFSR_SEED; index=0; busy=1.
  - start while busy is ignored.
- APPLY (1 cycle): register the pattern for the current index into dut_a/dut_b/dut_mode. Register the expected {ovf,cout,sum} from the reference model. → SETTLE.
- SETTLE: wait SETTLE_CYCLES cycles; dut_* held stable. → CHECK.
- CHECK (1 cycle): compare the three fields independently. Add 1 to err_count per mismatching field, so 0..3 per pattern, saturating. On the first pattern with any mismatch, latch first_err_idx=index.
  - If index==NUM_PATTERNS-1 → DONE. Otherwise index+1 and → APPLY.
  - Pattern period: SETTLE_CYCLES+2 cycles.
- DONE: busy=0, done=1, pass=(err_count==0). dut_* hold the last pattern.
- Directed patterns (index 0..3), given as a, b, mode:
  - 0: 7FFF, 0001, add
  - 1: 8000, 0001, sub
  - 2: FFFF, 0001, add
  - 3: 0000, 0001, sub
- Random patterns (index ≥4):
  - LFSR is 32-bit Fibonacci, taps x^32+x^22+x^2+x+1, shifted once per APPLY.
  - a = lfsr[15:0], b = lfsr[31:16], mode = lfsr[7] (value after the shift).
- Reference model:
  - Add: {cout,sum} = a + b (17-bit).
  - Sub: {cout,sum} = a + ~b + 1, so cout=1 means no borrow.
  - ovf = (a[15]==b'[15]) && (sum[15]!=a[15]), where b' = b for add and ~b for sub.
- Compares use exact equality. X/Z on DUT inputs counts as a mismatch in simulation.

Test Plan:
- Correct adder, NUM_PATTERNS=4, SETTLE_CYCLES=1, start pulse → done exactly 12 cycles after the APPLY entry; pass=1, err_count=0, first_err_idx=0. Expected {ovf,cout,sum} per pattern: 0→{1,0,8000}, 1→{1,1,7FFF}, 2→{0,1,0000}, 3→{0,0,FFFF}.
- Adder with cout stuck at 0, NUM_PATTERNS=4 → err_count=2, first_err_idx=1, pass=0.
- Correct adder, default parameters → done after 30000 cycles, pass=1. A second start reproduces the identical dut_a/dut_b/dut_mode sequence.
- rst asserted during SETTLE of pattern 2 → next cycle all outputs are at reset values and busy=0. A new start runs from index 0.
- start pulsed while busy → no effect on index or counts. start in DONE → counters clear and the run restarts.
- Adder whose sum is inverted on all patterns, NUM_PATTERNS=10000 → err_count ≥10000 and ≤17'h1FFFF (no wrap), first_err_idx=0.
